button_pulser: RTL and testbench



---
 rtl/sync_2ff.sv | 21 ++
 rtl/button_pulser.sv | 123 ++++++++++++
 tb/tb_button_pulser.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/button_pulser.sv
// Push-button front end: synchronize, debounce, emit one-cycle increment pulses with
// optional hold-to-auto-repeat. All outputs are registered.
module button_pulser #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
  parameter logic [22:0] REPEAT_PERIOD   = 23'd5000000,
  parameter logic        REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = $clog2(
      (32'(DEBOUNCE_CYCLES) > 32'(REPEAT_DELAY)) ?
        ((32'(DEBOUNCE_CYCLES) > 32'(REPEAT_PERIOD)) ? 32'(DEBOUNCE_CYCLES)
                                                     : 32'(REPEAT_PERIOD)) :
        ((32'(REPEAT_DELAY) > 32'(REPEAT_PERIOD)) ? 32'(REPEAT_DELAY)
                                                  : 32'(REPEAT_PERIOD)))
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic en,
  output logic incr,
  output logic pressed,
  output logic repeating
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StDbPress    = 3'd1;
  localparam logic [2:0] StHeldDelay  = 3'd2;
  localparam logic [2:0] StHeldRepeat = 3'd3;
  localparam logic [2:0] StDbRelease  = 3'd4;

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 20'd1);
  localparam logic [CNT_W-1:0] RdLast = CNT_W'(REPEAT_DELAY - 25'd1);
  localparam logic [CNT_W-1:0] RpLast = CNT_W'(REPEAT_PERIOD - 23'd1);

  logic             btn_sync;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      incr      <= 1'b0;
      pressed   <= 1'b0;
      repeating <= 1'b0;
    end else begin
      incr <= 1'b0;
      case (state)
        StIdle: begin
          cnt <= '0;
          if (btn_sync) state <= StDbPress;
        end
        StDbPress: begin
          if (!btn_sync) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (cnt == DbLast) begin
            state   <= StHeldDelay;
            cnt     <= '0;
            pressed <= 1'b1;
            incr    <= en;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHeldDelay: begin
          if (!btn_sync) begin
            state <= StDbRelease;
            cnt   <= '0;
          end else if (cnt == RdLast) begin
            // Without auto-repeat the counter simply parks at its last value.
            if (REPEAT_EN) begin
              state     <= StHeldRepeat;
              cnt       <= '0;
              incr      <= en;
              repeating <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHeldRepeat: begin
          if (!btn_sync) begin
            state     <= StDbRelease;
            cnt       <= '0;
            repeating <= 1'b0;
          end else if (cnt == RpLast) begin
            cnt  <= '0;
            incr <= en;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDbRelease: begin
          // A release bounce returns to the held state silently and restarts the delay.
          if (btn_sync) begin
            state <= StHeldDelay;
            cnt   <= '0;
          end else if (cnt == DbLast) begin
            state   <= StIdle;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          cnt       <= '0;
          pressed   <= 1'b0;
          repeating <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_pulser.sv
// Directed bench for button_pulser: expected pulse cycles are queued as stimulus is
// applied and every cycle's incr is compared against the head of the queue.
module tb_button_pulser;

  logic clk = 1'b0;
  logic rst, btn, btn0, en;
  logic incr, pressed, repeating;
  logic incr0, pressed0, repeating0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c;
  int q1[$];
  int q0[$];
  int rep_off[7] = '{7, 17, 20, 23, 26, 29, 32};

  always #5 clk = ~clk;

  button_pulser #(
    .DEBOUNCE_CYCLES (20'd4),
    .REPEAT_DELAY    (25'd10),
    .REPEAT_PERIOD   (23'd3),
    .REPEAT_EN       (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn),
    .en        (en),
    .incr      (incr),
    .pressed   (pressed),
    .repeating (repeating)
  );

  button_pulser #(
    .DEBOUNCE_CYCLES (20'd4),
    .REPEAT_DELAY    (25'd10),
    .REPEAT_PERIOD   (23'd3),
    .REPEAT_EN       (1'b0)
  ) dut_norep (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn0),
    .en        (1'b1),
    .incr      (incr0),
    .pressed   (pressed0),
    .repeating (repeating0)
  );

  task automatic chk(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", name, cyc, obs, exp);
    end
  endtask

  // Advance one edge, then compare both incr outputs against the scoreboard.
  task automatic tick();
    logic e1, e0;
    @(posedge clk);
    cyc++;
    #1;
    e1 = (q1.size() > 0 && q1[0] == cyc);
    if (e1) void'(q1.pop_front());
    e0 = (q0.size() > 0 && q0[0] == cyc);
    if (e0) void'(q0.pop_front());
    chk("incr", incr, e1);
    chk("incr_norep", incr0, e0);
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; btn0 = 1'b0; en = 1'b1;
    tick();
    tick();
    chk("reset_pressed", pressed, 1'b0);
    chk("reset_repeating", repeating, 1'b0);
    chk("reset_pressed_norep", pressed0, 1'b0);
    rst = 1'b0;
    run_to(4);

    // Clean press, held 8 cycles
    c = cyc; btn = 1'b1; q1.push_back(c + 7);
    run_to(c + 6);  chk("clean_pressed_pre", pressed, 1'b0);
    run_to(c + 7);  chk("clean_pressed_rise", pressed, 1'b1);
    run_to(c + 8);  btn = 1'b0;
    run_to(c + 14); chk("clean_pressed_hold", pressed, 1'b1);
    run_to(c + 15); chk("clean_pressed_fall", pressed, 1'b0);
    chk("clean_repeating", repeating, 1'b0);
    run_to(c + 20);

    // Press bounce: high 2, low 1, then held
    c = cyc; btn = 1'b1;
    run_to(c + 2); btn = 1'b0;
    run_to(c + 3); btn = 1'b1; q1.push_back(c + 10);
    run_to(c + 9);  chk("bounce_pressed_pre", pressed, 1'b0);
    run_to(c + 10); chk("bounce_pressed_rise", pressed, 1'b1);
    run_to(c + 12); btn = 1'b0;
    run_to(c + 22);

    // Auto-repeat, held 30 cycles
    c = cyc; btn = 1'b1;
    foreach (rep_off[i]) q1.push_back(c + rep_off[i]);
    run_to(c + 16); chk("rep_repeating_pre", repeating, 1'b0);
    run_to(c + 17); chk("rep_repeating_rise", repeating, 1'b1);
    run_to(c + 30); btn = 1'b0;
    run_to(c + 32); chk("rep_repeating_last", repeating, 1'b1);
    run_to(c + 33); chk("rep_repeating_fall", repeating, 1'b0);
    chk("rep_pressed_release", pressed, 1'b1);
    run_to(c + 36); chk("rep_pressed_hold", pressed, 1'b1);
    run_to(c + 37); chk("rep_pressed_fall", pressed, 1'b0);
    run_to(c + 40);

    // Release bounce while in the repeat delay
    c = cyc; btn = 1'b1; q1.push_back(c + 7);
    run_to(c + 8);  btn = 1'b0;
    run_to(c + 10); btn = 1'b1;
    q1.push_back(c + 23); q1.push_back(c + 26); q1.push_back(c + 29);
    run_to(c + 12); chk("relb_pressed", pressed, 1'b1);
    run_to(c + 22); chk("relb_repeating_pre", repeating, 1'b0);
    run_to(c + 23); chk("relb_repeating_rise", repeating, 1'b1);
    run_to(c + 27); btn = 1'b0;
    run_to(c + 36); chk("relb_pressed_fall", pressed, 1'b0);

    // en low only at the first pulse instant; the repeat timing must not shift
    c = cyc; en = 1'b0; btn = 1'b1;
    run_to(c + 7);  chk("gate_pressed", pressed, 1'b1);
    en = 1'b1; q1.push_back(c + 17);
    run_to(c + 16); btn = 1'b0;
    run_to(c + 17); chk("gate_repeating", repeating, 1'b1);
    run_to(c + 23); chk("gate_pressed_fall", pressed, 1'b0);
    run_to(c + 26);

    // REPEAT_EN=0 instance: one pulse for a 40-cycle hold
    c = cyc; btn0 = 1'b1; q0.push_back(c + 7);
    run_to(c + 30); chk("norep_repeating", repeating0, 1'b0);
    chk("norep_pressed", pressed0, 1'b1);
    run_to(c + 40); btn0 = 1'b0;
    run_to(c + 46); chk("norep_pressed_hold", pressed0, 1'b1);
    run_to(c + 47); chk("norep_pressed_fall", pressed0, 1'b0);
    run_to(c + 50);

    // Reset one cycle before a due repeat pulse, button still held
    c = cyc; btn = 1'b1;
    q1.push_back(c + 7); q1.push_back(c + 17); q1.push_back(c + 20);
    run_to(c + 22); chk("rst_repeating_pre", repeating, 1'b1);
    rst = 1'b1;
    run_to(c + 23); chk("rst_pressed", pressed, 1'b0);
    chk("rst_repeating", repeating, 1'b0);
    rst = 1'b0; q1.push_back(c + 30);
    run_to(c + 29); chk("rst_redebounce_pre", pressed, 1'b0);
    run_to(c + 30); chk("rst_redebounce_rise", pressed, 1'b1);
    run_to(c + 31); btn = 1'b0;
    run_to(c + 40); chk("rst_final_pressed", pressed, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
